// File: rtl/proximity_alarm_fsm.sv
// Proximity alarm FSM: qualifies ultrasonic distance samples into an
// intruder alarm and drives a gated square-wave tone for the DAC path.
// Optional build macro PROXIMITY_PITCH_EN: the tone half-period grows with the
// last near distance, so closer objects give a higher pitch.
module proximity_alarm_fsm #(
   parameter int unsigned THRESH_CM   = 50,
   parameter int unsigned CONFIRM_CNT = 3,
   parameter int unsigned CLEAR_CNT   = 5,
   parameter int unsigned TONE_HALF   = 25,
   parameter int unsigned BEEP_ON     = 2000,
   parameter int unsigned BEEP_OFF    = 1000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] Distance,
   input  logic       Dist_Valid,
   input  logic       Arm,
   input  logic       Silence,
   output logic       Sound,
   output logic       Alarm_Active,
   output logic [2:0] State
);

   localparam int unsigned NearW = $clog2(CONFIRM_CNT) + 1;
   localparam int unsigned FarW  = $clog2(CLEAR_CNT) + 1;
   localparam int unsigned BeepW = $clog2(BEEP_ON + BEEP_OFF) + 1;
`ifdef PROXIMITY_PITCH_EN
   // Largest half-period: TONE_HALF plus an 8-bit distance shifted right by 2.
   localparam int unsigned HalfMax = TONE_HALF + 63;
`else
   localparam int unsigned HalfMax = TONE_HALF;
`endif
   localparam int unsigned ToneW = $clog2(HalfMax) + 1;

   localparam logic [7:0]       ThreshCm = 8'(THRESH_CM);
   localparam logic [NearW-1:0] NearMax  = NearW'(CONFIRM_CNT);
   localparam logic [FarW-1:0]  FarMax   = FarW'(CLEAR_CNT);
   localparam logic [ToneW-1:0] ToneHalf = ToneW'(TONE_HALF);
   localparam logic [BeepW-1:0] BeepOn   = BeepW'(BEEP_ON);
   localparam logic [BeepW-1:0] BeepLast = BeepW'(BEEP_ON + BEEP_OFF - 1);

   typedef enum logic [2:0] {
      StDisarmed = 3'd0,
      StArmed    = 3'd1,
      StPending  = 3'd2,
      StAlarm    = 3'd3,
      StSilenced = 3'd4
   } state_e;

   state_e           r_state, w_state;
   logic [NearW-1:0] r_near_cnt, w_near_cnt;
   logic [FarW-1:0]  r_far_cnt, w_far_cnt;
   logic [ToneW-1:0] r_tone_cnt, w_tone_cnt;
   logic [BeepW-1:0] r_beep_cnt, w_beep_cnt;
   logic             r_tone, w_tone;
   logic             r_sound, w_sound;
   logic             r_alarm, w_alarm;
   logic             w_near, w_far;
   logic [ToneW-1:0] w_period;

`ifdef PROXIMITY_PITCH_EN
   logic [7:0]       r_last_near, w_last_near;
   logic [ToneW-1:0] r_half, w_half, w_half_load;

   // Latch the distance of every near sample and derive the pending half-period.
   always_comb begin
      w_last_near = w_near ? Distance : r_last_near;
      w_half_load = ToneHalf + ToneW'(w_last_near >> 2);
      w_period    = r_half;
   end
`else
   assign w_period = ToneHalf;
`endif

   // Zero distance means no echo and is neither near nor far.
   assign w_near = Dist_Valid && (Distance != 8'd0) && (Distance < ThreshCm);
   assign w_far  = Dist_Valid && (Distance >= ThreshCm);

   // Sample counters, next state and counter clearing on DISARMED/ARMED entry.
   always_comb begin
      w_near_cnt = r_near_cnt;
      w_far_cnt  = r_far_cnt;
      if (w_near) begin
         w_near_cnt = (r_near_cnt == NearMax) ? r_near_cnt : r_near_cnt + 1'b1;
         w_far_cnt  = '0;
      end else if (w_far) begin
         w_far_cnt  = (r_far_cnt == FarMax) ? r_far_cnt : r_far_cnt + 1'b1;
         w_near_cnt = '0;
      end

      w_state = r_state;
      if (!Arm) begin
         w_state = StDisarmed;
      end else begin
         unique case (r_state)
            StDisarmed: w_state = StArmed;
            StArmed: begin
               if (w_near) w_state = (w_near_cnt == NearMax) ? StAlarm : StPending;
            end
            StPending: begin
               if (w_far) w_state = StArmed;
               else if (w_near && (w_near_cnt == NearMax)) w_state = StAlarm;
            end
            StAlarm: begin
               // A clearing sample beats a simultaneous Silence.
               if (w_far && (w_far_cnt == FarMax)) w_state = StArmed;
               else if (Silence) w_state = StSilenced;
            end
            StSilenced: begin
               if (w_far && (w_far_cnt == FarMax)) w_state = StArmed;
            end
            default: w_state = StDisarmed;
         endcase
      end

      if ((w_state == StDisarmed) || ((w_state == StArmed) && (r_state != StArmed))) begin
         w_near_cnt = '0;
         w_far_cnt  = '0;
      end

      w_alarm = (w_state == StAlarm) || (w_state == StSilenced);
   end

   // Tone and cadence counters run only while staying in ALARM; entry restarts them.
   always_comb begin
      w_tone_cnt = '0;
      w_beep_cnt = '0;
      w_tone     = 1'b0;
`ifdef PROXIMITY_PITCH_EN
      w_half     = w_half_load;
`endif
      if ((r_state == StAlarm) && (w_state == StAlarm)) begin
         w_tone = r_tone;
`ifdef PROXIMITY_PITCH_EN
         w_half = r_half;
`endif
         if (r_tone_cnt == w_period - 1'b1) begin
            w_tone_cnt = '0;
            w_tone     = ~r_tone;
`ifdef PROXIMITY_PITCH_EN
            // New pitch only takes effect at a period boundary.
            w_half     = w_half_load;
`endif
         end else begin
            w_tone_cnt = r_tone_cnt + 1'b1;
         end
         w_beep_cnt = (r_beep_cnt == BeepLast) ? '0 : r_beep_cnt + 1'b1;
      end
      w_sound = (w_state == StAlarm) && w_tone && (w_beep_cnt < BeepOn);
   end

   // Single state register bank including the registered outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state     <= StDisarmed;
         r_near_cnt  <= '0;
         r_far_cnt   <= '0;
         r_tone_cnt  <= '0;
         r_beep_cnt  <= '0;
         r_tone      <= 1'b0;
         r_sound     <= 1'b0;
         r_alarm     <= 1'b0;
`ifdef PROXIMITY_PITCH_EN
         r_last_near <= 8'd0;
         r_half      <= ToneHalf;
`endif
      end else begin
         r_state     <= w_state;
         r_near_cnt  <= w_near_cnt;
         r_far_cnt   <= w_far_cnt;
         r_tone_cnt  <= w_tone_cnt;
         r_beep_cnt  <= w_beep_cnt;
         r_tone      <= w_tone;
         r_sound     <= w_sound;
         r_alarm     <= w_alarm;
`ifdef PROXIMITY_PITCH_EN
         r_last_near <= w_last_near;
         r_half      <= w_half;
`endif
      end
   end

   assign Sound        = r_sound;
   assign Alarm_Active = r_alarm;
   assign State        = r_state;

endmodule

// File: tb/tb_proximity_alarm_fsm.sv
// Scoreboard bench for proximity_alarm_fsm: the driver queues expected outputs
// tagged with the cycle they are due; a negedge monitor pops and compares.
module tb_proximity_alarm_fsm;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] Distance;
   logic       Dist_Valid;
   logic       Arm;
   logic       Silence;
   logic       Sound;
   logic       Alarm_Active;
   logic [2:0] State;

   proximity_alarm_fsm dut (
      .CLK          (CLK),
      .RST          (RST),
      .Distance     (Distance),
      .Dist_Valid   (Dist_Valid),
      .Arm          (Arm),
      .Silence      (Silence),
      .Sound        (Sound),
      .Alarm_Active (Alarm_Active),
      .State        (State)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int         due;
      string      name;
      logic [2:0] st;
      logic       al;
      logic       snd;
      bit         chk_snd;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_vec  = 0;
   int   n_bad  = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   // Monitor: compare every expectation due at this cycle.
   always @(negedge CLK) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         n_vec++;
         if (e.due != cyc || State !== e.st || Alarm_Active !== e.al ||
             (e.chk_snd && Sound !== e.snd)) begin
            n_bad++;
            $display("FAIL %s (cycle %0d, due %0d): State=%0d Alarm_Active=%b Sound=%b, required State=%0d Alarm_Active=%b Sound=%b",
                     e.name, cyc, e.due, State, Alarm_Active, Sound, e.st, e.al, e.snd);
         end
      end
   end

   task automatic put(input string nm, input int due, input logic [2:0] st, input logic al,
                      input bit chk, input logic snd);
      exp_t e;
      e.due = due; e.name = nm; e.st = st; e.al = al; e.chk_snd = chk; e.snd = snd;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [7:0] d, input logic v, input logic a, input logic s);
      Distance = d; Dist_Valid = v; Arm = a; Silence = s;
   endtask

   // Apply one cycle of inputs and expect the registered result after the next edge.
   task automatic step(input logic [7:0] d, input logic v, input logic a, input logic s,
                       input string nm, input logic [2:0] st, input logic al,
                       input bit chk, input logic snd);
      drive(d, v, a, s);
      put(nm, cyc + 1, st, al, chk, snd);
      tick();
   endtask

   // Sound k cycles after ALARM entry: toggles every 25, muted for cadence cycles 2000..2999.
   function automatic logic tone_model(input int k);
      return ((k / 25) % 2 == 1) && ((k % 3000) < 2000);
   endfunction

   task automatic confirm_alarm(input string nm);
      step(8'd30, 1, 1, 0, {nm, "_1"}, 3'd2, 0, 1, 0);
      step(8'd30, 1, 1, 0, {nm, "_2"}, 3'd2, 0, 1, 0);
      step(8'd30, 1, 1, 0, {nm, "_3"}, 3'd3, 1, 1, 0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b0;
      drive(8'd0, 0, 0, 0);
      tick();
      put("reset", cyc, 3'd0, 0, 1, 0);
      tick();
      RST = 1'b1;

      // Disarmed: near strobes do nothing.
      for (int i = 0; i < 3; i++) step(8'd10, 1, 0, 0, "disarmed_strobe", 3'd0, 0, 1, 0);
      step(8'd0, 0, 1, 0, "arm", 3'd1, 0, 1, 0);

      // Confirm with an idle gap between strobes.
      step(8'd30, 1, 1, 0, "confirm_1", 3'd2, 0, 1, 0);
      step(8'd0, 0, 1, 0, "confirm_gap", 3'd2, 0, 1, 0);
      step(8'd30, 1, 1, 0, "confirm_2", 3'd2, 0, 1, 0);
      step(8'd30, 1, 1, 0, "confirm_3", 3'd3, 1, 1, 0);

      // Tone and cadence across one full period and into the next.
      for (int k = 0; k <= 3050; k++) begin
         drive(8'd0, 0, 1, 0);
         put($sformatf("tone_k%0d", k), cyc, 3'd3, 1, 1, tone_model(k));
         tick();
      end

      // Clear: a near sample restarts the far run.
      for (int i = 0; i < 4; i++) step(8'd80, 1, 1, 0, "clear_far_a", 3'd3, 1, 0, 0);
      step(8'd20, 1, 1, 0, "clear_near", 3'd3, 1, 0, 0);
      for (int i = 0; i < 4; i++) step(8'd80, 1, 1, 0, "clear_far_b", 3'd3, 1, 0, 0);
      step(8'd80, 1, 1, 0, "clear_done", 3'd1, 0, 1, 0);

      // False trigger, then a zero sample that must be ignored.
      step(8'd30, 1, 1, 0, "false_1", 3'd2, 0, 1, 0);
      step(8'd30, 1, 1, 0, "false_2", 3'd2, 0, 1, 0);
      step(8'd80, 1, 1, 0, "false_far", 3'd1, 0, 1, 0);
      step(8'd30, 1, 1, 0, "zero_1", 3'd2, 0, 1, 0);
      step(8'd0, 1, 1, 0, "zero_ignored", 3'd2, 0, 1, 0);
      step(8'd30, 1, 1, 0, "zero_2", 3'd2, 0, 1, 0);
      step(8'd30, 1, 1, 0, "zero_confirm", 3'd3, 1, 1, 0);

      // Silence.
      step(8'd0, 0, 1, 1, "silence", 3'd4, 1, 1, 0);
      step(8'd10, 1, 1, 0, "silenced_near", 3'd4, 1, 1, 0);
      for (int i = 0; i < 4; i++) step(8'd200, 1, 1, 0, "silenced_far", 3'd4, 1, 1, 0);
      step(8'd200, 1, 1, 0, "silenced_clear", 3'd1, 0, 1, 0);
      step(8'd0, 0, 1, 1, "silence_armed", 3'd1, 0, 1, 0);
      step(8'd49, 1, 1, 0, "thresh_minus1", 3'd2, 0, 1, 0);
      step(8'd50, 1, 1, 0, "thresh_far", 3'd1, 0, 1, 0);

      // Clearing sample and Silence together: clear wins.
      confirm_alarm("sim");
      for (int i = 0; i < 4; i++) step(8'd80, 1, 1, 0, "sim_far", 3'd3, 1, 0, 0);
      step(8'd80, 1, 1, 1, "clear_beats_silence", 3'd1, 0, 1, 0);

      // Arm drop has priority and clears counters.
      confirm_alarm("drop");
      step(8'd30, 1, 0, 0, "arm_drop", 3'd0, 0, 1, 0);
      step(8'd0, 0, 1, 0, "rearm", 3'd1, 0, 1, 0);
      step(8'd30, 1, 1, 0, "counters_cleared", 3'd2, 0, 1, 0);
      step(8'd80, 1, 1, 0, "back_to_armed", 3'd1, 0, 1, 0);

      // Asynchronous reset while the tone is high.
      confirm_alarm("async");
      for (int k = 0; k <= 30; k++) begin
         drive(8'd0, 0, 1, 0);
         put("async_tone", cyc, 3'd3, 1, 1, tone_model(k));
         tick();
      end
      RST = 1'b0;
      #1;
      put("async_reset", cyc, 3'd0, 0, 1, 0);
      tick();
      RST = 1'b1;
      step(8'd0, 0, 1, 0, "post_reset_arm", 3'd1, 0, 1, 0);

      for (int i = 0; i < 4 && sb.size() > 0; i++) tick();
      if (sb.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
